// File: rtl/ac97_framer.sv
// ac97_framer: serializes one 256-bit AC'97 SDATA_OUT frame (tag, cmd addr/data, PCM L/R) per period
module ac97_framer (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic        down_stb,
  input  logic        down_ready,
  output logic        down_sync,
  output logic        down_data,
  input  logic        en,
  output logic        next_frame,
  input  logic        frame_valid,
  input  logic        addr_valid,
  input  logic [19:0] addr,
  input  logic        data_valid,
  input  logic [19:0] data,
  input  logic        pcmleft_valid,
  input  logic [19:0] pcmleft,
  input  logic        pcmright_valid,
  input  logic [19:0] pcmright
);
  logic [7:0]  cnt, cnt_n;
  logic [4:0]  tag_q, tag_s;
  logic [7:0]  tag8;
  logic [19:0] a_q, d_q, l_q, r_q, a_s, d_s, l_s, r_s;
  logic        xfer, load, bit_n;
  assign down_stb = en;
  assign xfer     = en & down_ready;
  assign load     = &cnt;
  // The bit offered next is derived from the post-transfer counter and shadow,
  // so the shadow load on bit 255 feeds bit 0 of the new frame directly.
  always_comb begin
    cnt_n = cnt + 8'd1;
    tag_s = load ? {pcmright_valid, pcmleft_valid, data_valid, addr_valid, frame_valid} : tag_q;
    a_s   = load ? addr : a_q;
    d_s   = load ? data : d_q;
    l_s   = load ? pcmleft : l_q;
    r_s   = load ? pcmright : r_q;
    tag8  = {3'b000, tag_s};
    bit_n = cnt_n < 8'd5  ? tag8[cnt_n[2:0]] :
            cnt_n < 8'd16 ? 1'b0 :
            cnt_n < 8'd36 ? tag_s[1] & a_s[5'(8'd35 - cnt_n)] :
            cnt_n < 8'd56 ? tag_s[2] & d_s[5'(8'd55 - cnt_n)] :
            cnt_n < 8'd76 ? tag_s[3] & l_s[5'(8'd75 - cnt_n)] :
            cnt_n < 8'd96 ? tag_s[4] & r_s[5'(8'd95 - cnt_n)] : 1'b0;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt        <= '0;
      tag_q      <= '0;
      a_q        <= '0;
      d_q        <= '0;
      l_q        <= '0;
      r_q        <= '0;
      down_sync  <= 1'b1;
      down_data  <= 1'b0;
      next_frame <= 1'b0;
    end else begin
      next_frame <= xfer & (cnt == 8'd0);
      if (xfer) begin
        cnt       <= cnt_n;
        tag_q     <= tag_s;
        a_q       <= a_s;
        d_q       <= d_s;
        l_q       <= l_s;
        r_q       <= r_s;
        down_sync <= cnt_n < 8'd16;
        down_data <= bit_n;
      end
    end
  end
endmodule

// File: tb/tb_ac97_framer.sv
// tb_ac97_framer: directed frame capture and checks for ac97_framer
module tb_ac97_framer;
  localparam logic [255:0] SYNC = 256'hFFFF;
  logic        sys_clk = 1'b0, sys_rst_n = 1'b0, down_ready = 1'b0, en = 1'b0;
  logic        down_stb, down_sync, down_data, next_frame;
  logic        fv, av, dv, plv, prv;
  logic [19:0] addr, data, pl, pr;
  logic [255:0] fd, fs, fn;
  int n_chk = 0, n_pass = 0, xcnt = 0, last_gap = 0, nf_bad = 0;
  bit prev_nf = 1'b0;

  always #5 sys_clk = ~sys_clk;

  ac97_framer dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .down_stb(down_stb), .down_ready(down_ready),
    .down_sync(down_sync), .down_data(down_data), .en(en), .next_frame(next_frame),
    .frame_valid(fv), .addr_valid(av), .addr(addr), .data_valid(dv), .data(data),
    .pcmleft_valid(plv), .pcmleft(pl), .pcmright_valid(prv), .pcmright(pr)
  );

  always @(posedge sys_clk) if (en && down_ready && sys_rst_n) xcnt++;
  always @(negedge sys_clk) begin
    if (next_frame) begin
      last_gap = xcnt;
      xcnt = 0;
      if (prev_nf) nf_bad++;
    end
    prev_nf = next_frame;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [255:0] exp_frame(input logic f, a_v, d_v, l_v, r_v,
                                             input logic [19:0] a, d, l, r);
    logic [255:0] v;
    v = '0;
    v[4:0] = {r_v, l_v, d_v, a_v, f};
    for (int j = 0; j < 20; j++) begin
      v[16 + j] = a_v & a[19 - j];
      v[36 + j] = d_v & d[19 - j];
      v[56 + j] = l_v & l[19 - j];
      v[76 + j] = r_v & r[19 - j];
    end
    return v;
  endfunction

  function automatic logic [19:0] slot(input logic [255:0] v, input int base);
    logic [19:0] s;
    for (int j = 0; j < 20; j++) s[19 - j] = v[base + j];
    return s;
  endfunction

  task automatic take(output logic d, output logic s, output logic nf);
    d = down_data;
    s = down_sync;
    en = 1'b1;
    down_ready = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    nf = next_frame;
  endtask

  task automatic run_frame(input int nbits, input bit stall, input int chg_at, input logic [19:0] chg_val,
                           output logic [255:0] od, output logic [255:0] os, output logic [255:0] on);
    logic d, s, nf, d0, s0;
    int len;
    od = '0; os = '0; on = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_at) addr = chg_val;
      if (stall && (i == 40 || $urandom_range(0, 3) == 0)) begin
        len = (i == 40) ? 50 : int'($urandom_range(1, 5));
        d0 = down_data;
        s0 = down_sync;
        en = (i == 40) ? 1'b0 : 1'($urandom_range(0, 1));
        down_ready = en ? 1'b0 : 1'($urandom_range(0, 1));
        repeat (len) begin
          @(posedge sys_clk);
          @(negedge sys_clk);
        end
        chk("stall_hold", 256'({down_stb, down_sync, down_data}), 256'({en, s0, d0}));
      end
      take(d, s, nf);
      od[i] = d; os[i] = s; on[i] = nf;
    end
    en = 1'b0;
    down_ready = 1'b0;
  endtask

  initial begin
    fv = 1'b1; av = 1'b1; addr = 20'hABCDE; dv = 1'b0; data = '0;
    plv = 1'b0; pl = '0; prv = 1'b0; pr = '0;
    #12;
    chk("reset_out", 256'({down_stb, down_sync, down_data, next_frame}), 256'(4'b0100));
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    run_frame(256, 1'b0, -1, '0, fd, fs, fn);
    chk("f1_data_zero", fd, '0);
    chk("f1_sync", fs, SYNC);
    chk("f1_next_frame", fn, 256'h1);

    dv = 1'b0; data = 20'hFFFFF; plv = 1'b1; pl = 20'h80001; prv = 1'b1; pr = 20'h7FFFF;
    addr = 20'h12345;
    run_frame(256, 1'b0, -1, '0, fd, fs, fn);
    chk("f2_frame", fd, exp_frame(1, 1, 0, 0, 0, 20'hABCDE, '0, '0, '0));
    chk("f2_tag", 256'(fd[15:0]), 256'(16'h0003));
    chk("f2_addr", 256'(slot(fd, 16)), 256'(20'hABCDE));
    chk("f2_sync", fs, SYNC);

    run_frame(256, 1'b1, -1, '0, fd, fs, fn);
    chk("f3_frame_stalled", fd, exp_frame(1, 1, 0, 1, 1, 20'h12345, 20'hFFFFF, 20'h80001, 20'h7FFFF));
    chk("f3_tag", 256'(fd[15:0]), 256'(16'h001B));
    chk("f3_data_masked", 256'(slot(fd, 36)), '0);
    chk("f3_pcmleft", 256'(slot(fd, 56)), 256'(20'h80001));
    chk("f3_pcmright", 256'(slot(fd, 76)), 256'(20'h7FFFF));
    chk("f3_tail_zero", 256'(fd[255:96]), '0);
    chk("f3_sync", fs, SYNC);
    chk("f3_next_frame", fn, 256'h1);
    chk("f3_gap", 256'(last_gap), 256'(256));

    run_frame(256, 1'b0, -1, '0, fd, fs, fn);
    chk("f4_frame", fd, exp_frame(1, 1, 0, 1, 1, 20'h12345, 20'hFFFFF, 20'h80001, 20'h7FFFF));
    chk("f4_gap", 256'(last_gap), 256'(256));
    chk("nf_width", 256'(nf_bad), '0);

    run_frame(256, 1'b0, 20, 20'h54321, fd, fs, fn);
    chk("f5_old_addr", 256'(slot(fd, 16)), 256'(20'h12345));
    run_frame(256, 1'b0, -1, '0, fd, fs, fn);
    chk("f6_new_addr", 256'(slot(fd, 16)), 256'(20'h54321));
    chk("f6_frame", fd, exp_frame(1, 1, 0, 1, 1, 20'h54321, 20'hFFFFF, 20'h80001, 20'h7FFFF));

    run_frame(100, 1'b0, -1, '0, fd, fs, fn);
    chk("f7_partial", 256'(fd[99:0]),
        256'(exp_frame(1, 1, 0, 1, 1, 20'h54321, 20'hFFFFF, 20'h80001, 20'h7FFFF) & {156'b0, {100{1'b1}}}));
    en = 1'b1;
    down_ready = 1'b1;
    sys_rst_n = 1'b0;
    #1;
    chk("midreset_out", 256'({down_sync, down_data, next_frame}), 256'(3'b100));
    repeat (3) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk("midreset_hold", 256'({down_sync, down_data, next_frame}), 256'(3'b100));
    end
    sys_rst_n = 1'b1;
    run_frame(256, 1'b0, -1, '0, fd, fs, fn);
    chk("f8_zero_frame", fd, '0);
    chk("f8_sync", fs, SYNC);
    chk("f8_next_frame", fn, 256'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
